sync_updown_mod_counter: RTL and testbench

//  - Parametrised synchronous up/down counter with count enable, synchronous parallel load
//    and a runtime-programmable terminal value (modulus = limit+1).
//  - Next generation of the 4-bit up/down counter: generalised width, decade/modulo-N

---
 rtl/sync_updown_mod_counter_if.sv | 31 +++
 rtl/sync_updown_mod_counter.sv | 81 ++++++++
 tb/tb_sync_updown_mod_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_updown_mod_counter_if.sv
// Bus bundle for sync_updown_mod_counter: count controls, load data,
// terminal value, and the registered count plus its status flags.
//
// Signalling: there is no valid/ready handshake on this bus. Every control
// input is sampled on each rising clk edge. qout, ovf and unf are registered.
// tc is combinational from the inputs and qout.
interface sync_updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             t;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] qout;
    logic             tc;
    logic             ovf;
    logic             unf;

    // Driver side: a controller or the previous stage in a cascade.
    modport master (
        output t, mode, load, din, limit,
        input  qout, tc, ovf, unf
    );

    // Counter side.
    modport slave (
        input  t, mode, load, din, limit,
        output qout, tc, ovf, unf
    );
endinterface

// File: rtl/sync_updown_mod_counter.sv
// Modulo-(limit+1) synchronous up/down counter with synchronous load,
// terminal-count lookahead and registered one-cycle overflow/underflow pulses.
// Optional feature macro: UDCNT_SATURATE_EN. When it is defined, the counter
// saturates at limit and at 0 instead of wrapping.
module sync_updown_mod_counter #(
    parameter int             WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sync_updown_mod_counter_if.slave   bus
);

    logic [WIDTH-1:0] qout_q, qout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_top;
    logic             at_zero;

    // ">=" and not "==", so that a loaded value above limit wraps on the next up-count.
    assign at_top  = (qout_q >= bus.limit);
    assign at_zero = (qout_q == '0);

    // Next-state selection. Priority is load, then count enable, then hold.
    // Both flags default low, so each one lasts a single cycle.
    always_comb begin
        qout_d = qout_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (bus.load) begin
            qout_d = bus.din;
        end else if (bus.t) begin
            if (!bus.mode) begin
                if (at_top) begin
                    ovf_d  = 1'b1;
`ifdef UDCNT_SATURATE_EN
                    qout_d = bus.limit;
`else
                    qout_d = '0;
`endif
                end else begin
                    qout_d = qout_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    unf_d  = 1'b1;
`ifdef UDCNT_SATURATE_EN
                    qout_d = '0;
`else
                    qout_d = bus.limit;
`endif
                end else begin
                    // Above limit this still steps down one, so the count walks back into range.
                    qout_d = qout_q - 1'b1;
                end
            end
        end
    end

    // State registers. Asynchronous reset to RST_VAL with both flags cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= RST_VAL;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            qout_q <= qout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Terminal-count lookahead, high in the cycle before the edge that sets ovf or unf.
    assign bus.tc = bus.t & ~bus.load &
                    ((~bus.mode & at_top) | (bus.mode & at_zero));

    assign bus.qout = qout_q;
    assign bus.ovf  = ovf_q;
    assign bus.unf  = unf_q;

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// Directed testbench for sync_updown_mod_counter (WIDTH=4, RST_VAL=0).
// The wrap checks are compiled in the default build.
// The saturation checks are compiled when UDCNT_SATURATE_EN is defined.
module tb_sync_updown_mod_counter;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sync_updown_mod_counter_if #(.WIDTH(W)) bus ();

    sync_updown_mod_counter #(
        .WIDTH  (W),
        .RST_VAL(4'd0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t_v, input logic mode_v, input logic load_v,
                         input logic [W-1:0] din_v, input logic [W-1:0] limit_v);
        bus.t     = t_v;
        bus.mode  = mode_v;
        bus.load  = load_v;
        bus.din   = din_v;
        bus.limit = limit_v;
        #1;
    endtask

    // Compares one observed value with its expected value; a mismatch counts as an error.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [W-1:0] q,
                             input logic o, input logic u);
        chk({tag, ".qout"}, 32'(bus.qout), 32'(q));
        chk({tag, ".ovf"},  32'(bus.ovf),  32'(o));
        chk({tag, ".unf"},  32'(bus.unf),  32'(u));
    endtask

    initial begin
        logic [W-1:0] exp_q;
        logic         exp_o;
        logic         exp_u;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd15);
        step();
        step();
        chk_state("reset_hold", 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Up count with limit=15 over 20 edges
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
        exp_q = 4'd0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("up_tc_%0d", i), 32'(bus.tc), 32'(exp_q == 4'd15));
            step();
`ifdef UDCNT_SATURATE_EN
            exp_o = (exp_q == 4'd15);
            exp_q = (exp_q == 4'd15) ? 4'd15 : exp_q + 4'd1;
`else
            exp_o = (exp_q == 4'd15);
            exp_q = (exp_q == 4'd15) ? 4'd0 : exp_q + 4'd1;
`endif
            chk_state($sformatf("up_%0d", i), exp_q, exp_o, 1'b0);
        end

        // Load 4, count to 7, then assert reset in mid-cycle with no clock edge
        drive(1'b0, 1'b0, 1'b1, 4'd4, 4'd15);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
        step();
        step();
        step();
        chk_state("pre_reset", 4'd7, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_reset", 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
        step();
        rst_n = 1'b1;
        #1;

`ifndef UDCNT_SATURATE_EN
        // Decade down count from 0: 9,8,...,0,9
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        exp_q = 4'd0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("dn_tc_%0d", i), 32'(bus.tc), 32'(exp_q == 4'd0));
            step();
            exp_u = (exp_q == 4'd0);
            exp_q = (exp_q == 4'd0) ? 4'd9 : exp_q - 4'd1;
            chk_state($sformatf("dn_%0d", i), exp_q, 1'b0, exp_u);
        end
`endif

        // Load takes priority over t. din=12 is above limit=9.
        drive(1'b1, 1'b0, 1'b1, 4'd12, 4'd9);
        chk("load_tc", 32'(bus.tc), 32'd0);
        step();
        chk_state("load12", 4'd12, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
        chk("above_limit_tc", 32'(bus.tc), 32'd1);
        step();
`ifdef UDCNT_SATURATE_EN
        chk_state("above_limit_up", 4'd9, 1'b1, 1'b0);
`else
        chk_state("above_limit_up", 4'd0, 1'b1, 1'b0);
`endif

        // Load 12 again, then count down into range: 11, 10, 9
        drive(1'b1, 1'b1, 1'b1, 4'd12, 4'd9);
        step();
        chk_state("reload12", 4'd12, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        step();
        chk_state("above_dn11", 4'd11, 1'b0, 1'b0);
        step();
        chk_state("above_dn10", 4'd10, 1'b0, 1'b0);
        step();
        chk_state("above_dn9", 4'd9, 1'b0, 1'b0);

        // Hold with t=0 for 3 edges. tc stays low.
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("hold_%0d", i), 4'd9, 1'b0, 1'b0);
            chk($sformatf("hold_tc_%0d", i), 32'(bus.tc), 32'd0);
        end

        // Switch mode at qout=5: the next edge gives 4
        drive(1'b0, 1'b0, 1'b1, 4'd4, 4'd9);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
        step();
        chk_state("mode_up5", 4'd5, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        step();
        chk_state("mode_dn4", 4'd4, 1'b0, 1'b0);

        // limit=0: each enabled edge gives qout=0 and a flag
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("lim0_tc_up", 32'(bus.tc), 32'd1);
        step();
        chk_state("lim0_up_a", 4'd0, 1'b1, 1'b0);
        step();
        chk_state("lim0_up_b", 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("lim0_tc_dn", 32'(bus.tc), 32'd1);
        step();
        chk_state("lim0_dn", 4'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        step();
        chk_state("lim0_idle", 4'd0, 1'b0, 1'b0);

`ifdef UDCNT_SATURATE_EN
        // Saturate at limit=9 from 8, then at 0 from 1
        drive(1'b0, 1'b0, 1'b1, 4'd8, 4'd9);
        step();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
        step();
        chk_state("sat_up_a", 4'd9, 1'b0, 1'b0);
        step();
        chk_state("sat_up_b", 4'd9, 1'b1, 1'b0);
        step();
        chk_state("sat_up_c", 4'd9, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'd1, 4'd9);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
        step();
        chk_state("sat_dn_a", 4'd0, 1'b0, 1'b0);
        step();
        chk_state("sat_dn_b", 4'd0, 1'b0, 1'b1);
`endif

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
